game_session_ctrl: RTL
======================

// Module: game_session_ctrl
// PURPOSE
//  Session sequencer for the infinity game mode. Turns the start button into a full round:
//  idle, visible pre-start countdown, play, then game-over display with a hold time.
//  Drives enable_game_infinity and a one-cycle score-clear pulse into the game logic, and
//  consumes its gameover/score_infinity outputs. Keeps last-round and best scores for the display.
// PARAMETERS
//  TICK_DIV   100000000  clk cycles per 1 s tick (100 MHz board clock)
//  COUNT_S    3          pre-start countdown length, seconds (1..15)
//  HOLD_S     5          game-over display hold, seconds (1..15)
// PORTS
//  clk           in   1  system clock
//  rst           in   1  asynchronous reset, active-high
//  btn_start     in   1  start button, level, already debounced/synchronised
//  gameover_in   in   1  round-finished flag from game logic (level or pulse)
//  score_in      in   6  final round score from game logic, valid while gameover_in=1
//  enable_game   out  1  enable to game logic; high only in PLAY
//  clear_score   out  1  one-cycle pulse, clears game-logic score (sw[0] equivalent)
//  countdown     out  4  seconds remaining in COUNTDOWN/OVER, else 0
//  state_o       out  3  0=IDLE 1=COUNTDOWN 2=PLAY 3=OVER
//  last_score    out  6  score of most recent completed round
//  best_score    out  6  highest completed-round score since reset
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, all outputs 0, tick counter 0, btn_q=1
//   (a start button held through reset does not start a round).
//  start_edge = btn_start & ~btn_q; btn_q registered every cycle.
//  Tick: counter cnt 0..TICK_DIV-1, tick=1 when cnt==TICK_DIV-1; cnt forced to 0 on every
//   state change so the first tick after entry is exactly TICK_DIV cycles later.
//  IDLE: start_edge -> COUNTDOWN next cycle; countdown<=COUNT_S, clear_score=1 for that one cycle.
//   Anything else ignored.
//  COUNTDOWN: on tick countdown decrements; tick with countdown==1 -> PLAY, countdown<=0,
//   enable_game=1 from the PLAY entry cycle. PLAY entered COUNT_S*TICK_DIV cycles after entry.
//   start_edge restarts countdown at COUNT_S and re-pulses clear_score.
//  PLAY: enable_game=1. First cycle with gameover_in=1 -> OVER: last_score<=score_in;
//   best_score<=score_in if score_in > best_score (strict; ties leave best unchanged);
//   enable_game=0 from OVER entry; countdown<=HOLD_S. start_edge ignored in PLAY.
//  OVER: on tick countdown decrements; tick with countdown==1 -> IDLE, countdown<=0.
//   start_edge during OVER ignored (hold always completes). gameover_in level ignored.
//  Simultaneous start_edge and tick in COUNTDOWN: restart wins.
//  Simultaneous gameover_in and tick in PLAY: gameover wins (tick unused in PLAY).
//  All outputs registered; state_o mirrors state register. Scores saturate-free (6-bit direct copy).
//  Reset mid-round: enable_game drops asynchronously; last_score and best_score lost.
// TESTING  (TICK_DIV=4, COUNT_S=3, HOLD_S=2)
//  Hold btn_start=1 across reset release -> state stays 0, no clear_score, until release+press.
//  Press in IDLE -> next cycle state=1, countdown=3, clear_score=1 for 1 cycle; countdown 2,1 at
//   +4,+8 cycles; state=2 and enable_game=1 at +12 cycles.
//  Re-press at +6 in COUNTDOWN -> countdown back to 3, second clear_score pulse, PLAY at +12 from re-press.
//  In PLAY, gameover_in=1 with score_in=17 -> next cycle state=3, enable_game=0, last=17, best=17,
//   countdown=2; IDLE 8 cycles after OVER entry.
//  Second round score_in=9 -> last=9, best=17; third round score_in=17 -> best stays 17.
//  Press during OVER -> ignored, IDLE on schedule; async rst mid-PLAY -> enable_game=0 immediately,
//   all scores 0.

Source files
------------

// File: rtl/game_session_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : game_session_ctrl
// Description : Infinity-mode session sequencer. It runs each round through
//               idle, a visible countdown, play, and a timed game-over hold.
//               It also keeps the last-round and best scores.
// Revision    : 1.0 - initial release
// ============================================================================
module game_session_ctrl #(
    parameter int TICK_DIV = 100000000,
    parameter int COUNT_S  = 3,
    parameter int HOLD_S   = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       gameover_in,
    input  logic [5:0] score_in,
    output logic       enable_game,
    output logic       clear_score,
    output logic [3:0] countdown,
    output logic [2:0] state_o,
    output logic [5:0] last_score,
    output logic [5:0] best_score
);

    localparam int              CNT_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [3:0]      COUNT_INIT = 4'(COUNT_S);
    localparam logic [3:0]      HOLD_INIT  = 4'(HOLD_S);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_PLAY      = 3'd2,
        S_OVER      = 3'd3
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             btn_q;
    logic             enable_q;
    logic             clear_q;
    logic [3:0]       countdown_q;
    logic [5:0]       last_q;
    logic [5:0]       best_q;

    logic             start_edge;
    logic             tick;

    assign start_edge = btn_start & ~btn_q;
    assign tick       = (cnt_q == TICK_LAST);
    assign cnt_d      = tick ? '0 : cnt_q + CNT_W'(1);

    // The tick counter free-runs. Every state change or countdown restart
    // clears it, so the first tick arrives exactly TICK_DIV cycles after entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            btn_q       <= 1'b1;
            enable_q    <= 1'b0;
            clear_q     <= 1'b0;
            countdown_q <= 4'd0;
            last_q      <= 6'd0;
            best_q      <= 6'd0;
        end else begin
            btn_q   <= btn_start;
            clear_q <= 1'b0;
            cnt_q   <= cnt_d;

            case (state_q)
                S_IDLE: begin
                    if (start_edge) begin
                        state_q     <= S_COUNTDOWN;
                        countdown_q <= COUNT_INIT;
                        clear_q     <= 1'b1;
                        cnt_q       <= '0;
                    end
                end

                S_COUNTDOWN: begin
                    if (start_edge) begin
                        countdown_q <= COUNT_INIT;
                        clear_q     <= 1'b1;
                        cnt_q       <= '0;
                    end else if (tick) begin
                        if (countdown_q == 4'd1) begin
                            state_q     <= S_PLAY;
                            countdown_q <= 4'd0;
                            enable_q    <= 1'b1;
                            cnt_q       <= '0;
                        end else begin
                            countdown_q <= countdown_q - 4'd1;
                        end
                    end
                end

                S_PLAY: begin
                    if (gameover_in) begin
                        state_q     <= S_OVER;
                        enable_q    <= 1'b0;
                        countdown_q <= HOLD_INIT;
                        last_q      <= score_in;
                        cnt_q       <= '0;
                        // A tie leaves the best score unchanged.
                        if (score_in > best_q) begin
                            best_q <= score_in;
                        end
                    end
                end

                S_OVER: begin
                    if (tick) begin
                        if (countdown_q == 4'd1) begin
                            state_q     <= S_IDLE;
                            countdown_q <= 4'd0;
                            cnt_q       <= '0;
                        end else begin
                            countdown_q <= countdown_q - 4'd1;
                        end
                    end
                end

                default: begin
                    state_q     <= S_IDLE;
                    enable_q    <= 1'b0;
                    countdown_q <= 4'd0;
                    cnt_q       <= '0;
                end
            endcase
        end
    end

    assign enable_game = enable_q;
    assign clear_score = clear_q;
    assign countdown   = countdown_q;
    assign state_o     = state_q;
    assign last_score  = last_q;
    assign best_score  = best_q;

endmodule
`default_nettype wire
